// File: rtl/psr_cond_unit_pkg.sv
// Shared constants for the PSR/condition unit: ALU opcodes, condition codes,
// PSR bit positions and processor mode encodings.
package psr_cond_unit_pkg;

    localparam logic [3:0] OP_AND = 4'h0;
    localparam logic [3:0] OP_EOR = 4'h1;
    localparam logic [3:0] OP_SUB = 4'h2;
    localparam logic [3:0] OP_RSB = 4'h3;
    localparam logic [3:0] OP_ADD = 4'h4;
    localparam logic [3:0] OP_ADC = 4'h5;
    localparam logic [3:0] OP_SBC = 4'h6;
    localparam logic [3:0] OP_RSC = 4'h7;
    localparam logic [3:0] OP_TST = 4'h8;
    localparam logic [3:0] OP_TEQ = 4'h9;
    localparam logic [3:0] OP_CMP = 4'hA;
    localparam logic [3:0] OP_CMN = 4'hB;
    localparam logic [3:0] OP_ORR = 4'hC;
    localparam logic [3:0] OP_MOV = 4'hD;
    localparam logic [3:0] OP_BIC = 4'hE;
    localparam logic [3:0] OP_MVN = 4'hF;

    localparam logic [3:0] CC_EQ = 4'h0;
    localparam logic [3:0] CC_NE = 4'h1;
    localparam logic [3:0] CC_CS = 4'h2;
    localparam logic [3:0] CC_CC = 4'h3;
    localparam logic [3:0] CC_MI = 4'h4;
    localparam logic [3:0] CC_PL = 4'h5;
    localparam logic [3:0] CC_VS = 4'h6;
    localparam logic [3:0] CC_VC = 4'h7;
    localparam logic [3:0] CC_HI = 4'h8;
    localparam logic [3:0] CC_LS = 4'h9;
    localparam logic [3:0] CC_GE = 4'hA;
    localparam logic [3:0] CC_LT = 4'hB;
    localparam logic [3:0] CC_GT = 4'hC;
    localparam logic [3:0] CC_LE = 4'hD;
    localparam logic [3:0] CC_AL = 4'hE;
    localparam logic [3:0] CC_NV = 4'hF;

    localparam int PSR_N       = 31;
    localparam int PSR_Z       = 30;
    localparam int PSR_C       = 29;
    localparam int PSR_V       = 28;
    localparam int PSR_I       = 7;
    localparam int PSR_F       = 6;
    localparam int PSR_MODE_HI = 4;
    localparam int PSR_MODE_LO = 0;

    // Only NZCV, I, F and mode are stored; everything else reads as zero.
    localparam logic [31:0] PSR_MASK = 32'hF000_00DF;

    localparam logic [4:0] MODE_USR = 5'b10000;
    localparam logic [4:0] MODE_FIQ = 5'b10001;
    localparam logic [4:0] MODE_IRQ = 5'b10010;
    localparam logic [4:0] MODE_SVC = 5'b10011;
    localparam logic [4:0] MODE_ABT = 5'b10111;
    localparam logic [4:0] MODE_UND = 5'b11011;
    localparam logic [4:0] MODE_SYS = 5'b11111;

    function automatic logic is_arith(input logic [3:0] op);
        return (op == OP_SUB) || (op == OP_RSB) || (op == OP_ADD) || (op == OP_ADC) ||
               (op == OP_SBC) || (op == OP_RSC) || (op == OP_CMP) || (op == OP_CMN);
    endfunction

endpackage

// File: rtl/psr_cond_unit_if.sv
// Bus between ALU/decode and the PSR/condition unit.
interface psr_cond_unit_if;
    import psr_cond_unit_pkg::*;

    logic [3:0]  alu_op;
    logic        flag_we;
    logic        negative;
    logic        zero;
    logic        carry;
    logic        overflow;
    logic        shifter_carry;
    logic [3:0]  cond;
    logic        cond_pass;
    logic        cin;
    logic        psr_we;
    logic        psr_sel;
    logic [31:0] psr_wdata;
    logic        exc_entry;
    logic [4:0]  exc_mode;
    logic        exc_return;
    logic [31:0] cpsr;
    logic [31:0] spsr;

    modport master (
        output alu_op, flag_we, negative, zero, carry, overflow, shifter_carry, cond,
               psr_we, psr_sel, psr_wdata, exc_entry, exc_mode, exc_return,
        input  cond_pass, cin, cpsr, spsr
    );

    modport slave (
        input  alu_op, flag_we, negative, zero, carry, overflow, shifter_carry, cond,
               psr_we, psr_sel, psr_wdata, exc_entry, exc_mode, exc_return,
        output cond_pass, cin, cpsr, spsr
    );

endinterface

// File: rtl/psr_cond_unit_cond_eval.sv
// ARM condition-field evaluator: pure combinational, nzcv = {N,Z,C,V}.
module cond_eval
    import psr_cond_unit_pkg::*;
(
    input  logic [3:0] nzcv,
    input  logic [3:0] cond,
    output logic       pass
);

    logic n, z, c, v;

    always_comb begin
        {n, z, c, v} = nzcv;
        pass = 1'b0;
        case (cond)
            CC_EQ: pass = z;
            CC_NE: pass = !z;
            CC_CS: pass = c;
            CC_CC: pass = !c;
            CC_MI: pass = n;
            CC_PL: pass = !n;
            CC_VS: pass = v;
            CC_VC: pass = !v;
            CC_HI: pass = c && !z;
            CC_LS: pass = !c || z;
            CC_GE: pass = (n == v);
            CC_LT: pass = (n != v);
            CC_GT: pass = !z && (n == v);
            CC_LE: pass = z || (n != v);
            CC_AL: pass = 1'b1;
            default: pass = 1'b0;
        endcase
    end

endmodule

// File: rtl/psr_cond_unit.sv
// CPSR/SPSR holder with ARM flag-update rules, exception swaps and condition evaluation.
module psr_cond_unit
    import psr_cond_unit_pkg::*;
#(
    parameter bit         FWD_EN     = 1'b0,
    parameter logic [4:0] RESET_MODE = 5'b10011
) (
    input logic           clk,
    input logic           rst_n,
    psr_cond_unit_if.slave bus
);

    localparam logic [31:0] CPSR_RST = {4'b0000, 20'b0, 1'b1, 1'b1, 1'b0, RESET_MODE};

    logic [31:0] cpsr_q, cpsr_d;
    logic [31:0] spsr_q, spsr_d;
    logic [3:0]  nzcv_q;
    logic [3:0]  nzcv_alu;
    logic [3:0]  nzcv_eval;
    logic        flag_win;

    assign nzcv_q = cpsr_q[PSR_N:PSR_V];

    // Logical ops take C from the shifter and leave V alone.
    always_comb begin
        if (is_arith(bus.alu_op))
            nzcv_alu = {bus.negative, bus.zero, bus.carry, bus.overflow};
        else
            nzcv_alu = {bus.negative, bus.zero, bus.shifter_carry, nzcv_q[0]};
    end

    always_comb begin
        cpsr_d   = cpsr_q;
        spsr_d   = spsr_q;
        flag_win = 1'b0;
        if (bus.exc_entry) begin
            spsr_d = cpsr_q;
            cpsr_d[PSR_I] = 1'b1;
            cpsr_d[PSR_MODE_HI:PSR_MODE_LO] = bus.exc_mode;
        end else if (bus.exc_return) begin
            cpsr_d = spsr_q;
        end else if (bus.psr_we) begin
            if (bus.psr_sel)
                spsr_d = bus.psr_wdata & PSR_MASK;
            else
                cpsr_d = bus.psr_wdata & PSR_MASK;
        end else if (bus.flag_we) begin
            cpsr_d[PSR_N:PSR_V] = nzcv_alu;
            flag_win = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cpsr_q <= CPSR_RST;
            spsr_q <= '0;
        end else begin
            cpsr_q <= cpsr_d;
            spsr_q <= spsr_d;
        end
    end

    // Bypass only applies when the ALU flag write actually lands this cycle.
    assign nzcv_eval = (FWD_EN && rst_n && flag_win) ? nzcv_alu : nzcv_q;

    cond_eval u_cond_eval (
        .nzcv (nzcv_eval),
        .cond (bus.cond),
        .pass (bus.cond_pass)
    );

    assign bus.cin  = nzcv_eval[1];
    assign bus.cpsr = cpsr_q;
    assign bus.spsr = spsr_q;

endmodule

// File: tb/tb_psr_cond_unit.sv
// Bench for psr_cond_unit: directed vector table plus random run against a field-level PSR model,
// with one instance per bypass setting driven by identical stimulus.
module tb_psr_cond_unit;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    psr_cond_unit_if if0 ();
    psr_cond_unit_if if1 ();

    assign if1.alu_op        = if0.alu_op;
    assign if1.flag_we       = if0.flag_we;
    assign if1.negative      = if0.negative;
    assign if1.zero          = if0.zero;
    assign if1.carry         = if0.carry;
    assign if1.overflow      = if0.overflow;
    assign if1.shifter_carry = if0.shifter_carry;
    assign if1.cond          = if0.cond;
    assign if1.psr_we        = if0.psr_we;
    assign if1.psr_sel       = if0.psr_sel;
    assign if1.psr_wdata     = if0.psr_wdata;
    assign if1.exc_entry     = if0.exc_entry;
    assign if1.exc_mode      = if0.exc_mode;
    assign if1.exc_return    = if0.exc_return;

    psr_cond_unit #(.FWD_EN(1'b0), .RESET_MODE(5'b10011)) dut0 (.clk(clk), .rst_n(rst_n), .bus(if0));
    psr_cond_unit #(.FWD_EN(1'b1), .RESET_MODE(5'b10011)) dut1 (.clk(clk), .rst_n(rst_n), .bus(if1));

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    typedef struct {
        bit        rst;
        bit        fw;
        bit [3:0]  op;
        bit [3:0]  fl;     // {negative, zero, carry, overflow}
        bit        sc;
        bit [3:0]  cc;
        bit        pw;
        bit        ps;
        bit [31:0] wd;
        bit        ee;
        bit [4:0]  em;
        bit        er;
        bit        p0;     // cond_pass this cycle, no bypass
        bit        p1;     // cond_pass this cycle, bypass
        bit        c0;
        bit        c1;
        bit [31:0] cp;     // cpsr after the edge
        bit [31:0] sp;     // spsr after the edge
    } vec_t;

    // Field-level reference model
    typedef struct {
        bit n, z, c, v, i, f;
        bit [4:0] mode;
    } psr_t;

    function automatic bit [31:0] pack(psr_t p);
        return {p.n, p.z, p.c, p.v, 20'b0, p.i, p.f, 1'b0, p.mode};
    endfunction

    function automatic psr_t unpack(bit [31:0] w);
        psr_t p;
        p.n = w[31]; p.z = w[30]; p.c = w[29]; p.v = w[28];
        p.i = w[7];  p.f = w[6];  p.mode = w[4:0];
        return p;
    endfunction

    function automatic bit cond_ok(psr_t p, bit [3:0] cc);
        bit ge = (p.n == p.v);
        bit hi = p.c && !p.z;
        case (cc)
            0: return p.z;        1: return !p.z;
            2: return p.c;        3: return !p.c;
            4: return p.n;        5: return !p.n;
            6: return p.v;        7: return !p.v;
            8: return hi;         9: return !hi;
            10: return ge;        11: return !ge;
            12: return ge && !p.z; 13: return !(ge && !p.z);
            14: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic psr_t after_flags(psr_t p, bit [3:0] op, bit [3:0] fl, bit sc);
        psr_t q = p;
        q.n = fl[3];
        q.z = fl[2];
        if (op inside {4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd10, 4'd11}) begin
            q.c = fl[1];
            q.v = fl[0];
        end else begin
            q.c = sc;
        end
        return q;
    endfunction

    task automatic drive(input vec_t t);
        rst_n                = t.rst;
        if0.flag_we          = t.fw;
        if0.alu_op           = t.op;
        {if0.negative, if0.zero, if0.carry, if0.overflow} = t.fl;
        if0.shifter_carry    = t.sc;
        if0.cond             = t.cc;
        if0.psr_we           = t.pw;
        if0.psr_sel          = t.ps;
        if0.psr_wdata        = t.wd;
        if0.exc_entry        = t.ee;
        if0.exc_mode         = t.em;
        if0.exc_return       = t.er;
    endtask

    vec_t vecs[19];
    vec_t idle;
    psr_t m_c, m_s, fwd_c, rst_c;
    bit   fwd_win;

    initial begin
        idle = '{1, 0, 4'h0, 4'h0, 0, 4'hE, 0, 0, 32'h0, 0, 5'h0, 0, 0, 0, 0, 0, 32'h0, 32'h0};
        //         rst fw op    fl    sc cc    pw ps wd            ee em     er p0 p1 c0 c1 cpsr          spsr
        vecs[0]  = '{1, 0, 4'h0, 4'h0, 0, 4'h0, 0, 0, 32'h0,        0, 5'h00, 0, 0, 0, 0, 0, 32'h000000D3, 32'h0};
        vecs[1]  = '{1, 1, 4'h4, 4'h8, 0, 4'h4, 0, 0, 32'h0,        0, 5'h00, 0, 0, 1, 0, 0, 32'h800000D3, 32'h0};
        vecs[2]  = '{1, 0, 4'h0, 4'h0, 0, 4'h4, 0, 0, 32'h0,        0, 5'h00, 0, 1, 1, 0, 0, 32'h800000D3, 32'h0};
        vecs[3]  = '{1, 0, 4'h0, 4'h0, 0, 4'h5, 0, 0, 32'h0,        0, 5'h00, 0, 0, 0, 0, 0, 32'h800000D3, 32'h0};
        vecs[4]  = '{1, 0, 4'h0, 4'h0, 0, 4'hB, 0, 0, 32'h0,        0, 5'h00, 0, 1, 1, 0, 0, 32'h800000D3, 32'h0};
        vecs[5]  = '{1, 0, 4'h0, 4'h0, 0, 4'hA, 0, 0, 32'h0,        0, 5'h00, 0, 0, 0, 0, 0, 32'h800000D3, 32'h0};
        vecs[6]  = '{1, 1, 4'h4, 4'h1, 0, 4'hE, 0, 0, 32'h0,        0, 5'h00, 0, 1, 1, 0, 0, 32'h100000D3, 32'h0};
        vecs[7]  = '{1, 1, 4'h0, 4'h4, 1, 4'h0, 0, 0, 32'h0,        0, 5'h00, 0, 0, 1, 0, 1, 32'h700000D3, 32'h0};
        vecs[8]  = '{1, 0, 4'h0, 4'h0, 0, 4'h0, 0, 0, 32'h0,        0, 5'h00, 0, 1, 1, 1, 1, 32'h700000D3, 32'h0};
        vecs[9]  = '{1, 0, 4'h0, 4'h0, 0, 4'h8, 0, 0, 32'h0,        0, 5'h00, 0, 0, 0, 1, 1, 32'h700000D3, 32'h0};
        vecs[10] = '{1, 0, 4'h0, 4'h0, 0, 4'hE, 1, 0, 32'h600000D3, 0, 5'h00, 0, 1, 1, 1, 1, 32'h600000D3, 32'h0};
        vecs[11] = '{1, 0, 4'h0, 4'h0, 0, 4'hE, 0, 0, 32'h0,        1, 5'h12, 0, 1, 1, 1, 1, 32'h600000D2, 32'h600000D3};
        vecs[12] = '{1, 0, 4'h0, 4'h0, 0, 4'hE, 0, 0, 32'h0,        0, 5'h00, 1, 1, 1, 1, 1, 32'h600000D3, 32'h600000D3};
        vecs[13] = '{1, 1, 4'h4, 4'hF, 1, 4'h0, 0, 0, 32'h0,        1, 5'h12, 0, 1, 1, 1, 1, 32'h600000D2, 32'h600000D3};
        vecs[14] = '{1, 1, 4'h4, 4'h0, 0, 4'hE, 1, 1, 32'hFFFFFFFF, 0, 5'h00, 0, 1, 1, 1, 1, 32'h600000D2, 32'hF00000DF};
        vecs[15] = '{1, 0, 4'h0, 4'h0, 0, 4'hE, 1, 0, 32'hAFFFFF31, 0, 5'h00, 0, 1, 1, 1, 1, 32'hA0000011, 32'hF00000DF};
        vecs[16] = '{1, 0, 4'h0, 4'h0, 0, 4'hE, 1, 1, 32'h0,        0, 5'h00, 1, 1, 1, 1, 1, 32'hF00000DF, 32'hF00000DF};
        vecs[17] = '{0, 1, 4'h4, 4'h0, 0, 4'hE, 0, 0, 32'h0,        1, 5'h11, 0, 1, 1, 1, 1, 32'h000000D3, 32'h0};
        vecs[18] = '{1, 0, 4'h0, 4'h0, 0, 4'h2, 0, 0, 32'h0,        0, 5'h00, 0, 0, 0, 0, 0, 32'h000000D3, 32'h0};

        drive(idle);
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        drive(idle);
        @(negedge clk);
        chk("rst_cpsr0", if0.cpsr, 32'h000000D3);
        chk("rst_spsr0", if0.spsr, 32'h0);
        chk("rst_cin0",  {31'b0, if0.cin}, 32'h0);
        chk("rst_cpsr1", if1.cpsr, 32'h000000D3);
        chk("rst_pass_al", {31'b0, if0.cond_pass}, 32'h1);
        @(posedge clk);
        #1;

        for (int k = 0; k < 19; k++) begin
            drive(vecs[k]);
            @(negedge clk);
            chk($sformatf("v%0d_pass0", k), {31'b0, if0.cond_pass}, {31'b0, vecs[k].p0});
            chk($sformatf("v%0d_pass1", k), {31'b0, if1.cond_pass}, {31'b0, vecs[k].p1});
            chk($sformatf("v%0d_cin0", k),  {31'b0, if0.cin},       {31'b0, vecs[k].c0});
            chk($sformatf("v%0d_cin1", k),  {31'b0, if1.cin},       {31'b0, vecs[k].c1});
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_cpsr0", k), if0.cpsr, vecs[k].cp);
            chk($sformatf("v%0d_spsr0", k), if0.spsr, vecs[k].sp);
            chk($sformatf("v%0d_cpsr1", k), if1.cpsr, vecs[k].cp);
            chk($sformatf("v%0d_spsr1", k), if1.spsr, vecs[k].sp);
        end

        // Random phase: the table leaves both DUTs in the reset state.
        rst_c = unpack(32'h000000D3);
        m_c   = rst_c;
        m_s   = unpack(32'h0);
        for (int k = 0; k < 3000; k++) begin
            vec_t t;
            t = idle;
            t.rst = ($urandom_range(0, 63) != 0);
            t.fw  = $urandom_range(0, 1) != 0;
            t.op  = 4'($urandom_range(0, 15));
            t.fl  = 4'($urandom_range(0, 15));
            t.sc  = $urandom_range(0, 1) != 0;
            t.cc  = 4'($urandom_range(0, 15));
            t.pw  = ($urandom_range(0, 7) == 0);
            t.ps  = $urandom_range(0, 1) != 0;
            t.wd  = $urandom;
            t.ee  = ($urandom_range(0, 11) == 0);
            t.em  = 5'($urandom_range(0, 31));
            t.er  = ($urandom_range(0, 9) == 0);
            drive(t);

            fwd_win = t.rst && t.fw && !t.ee && !t.er && !t.pw;
            fwd_c   = fwd_win ? after_flags(m_c, t.op, t.fl, t.sc) : m_c;

            @(negedge clk);
            chk("r_pass0", {31'b0, if0.cond_pass}, {31'b0, cond_ok(m_c, t.cc)});
            chk("r_pass1", {31'b0, if1.cond_pass}, {31'b0, cond_ok(fwd_c, t.cc)});
            chk("r_cin0",  {31'b0, if0.cin}, {31'b0, m_c.c});
            chk("r_cin1",  {31'b0, if1.cin}, {31'b0, fwd_c.c});
            chk("r_cpsr0", if0.cpsr, pack(m_c));
            chk("r_spsr0", if0.spsr, pack(m_s));
            chk("r_cpsr1", if1.cpsr, pack(m_c));
            chk("r_spsr1", if1.spsr, pack(m_s));

            @(posedge clk);
            if (!t.rst) begin
                m_c = rst_c;
                m_s = unpack(32'h0);
            end else if (t.ee) begin
                m_s    = m_c;
                m_c.mode = t.em;
                m_c.i  = 1'b1;
            end else if (t.er) begin
                m_c = m_s;
            end else if (t.pw) begin
                if (t.ps) m_s = unpack(t.wd);
                else      m_c = unpack(t.wd);
            end else if (t.fw) begin
                m_c = after_flags(m_c, t.op, t.fl, t.sc);
            end
            #1;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
